reg_file: RTL and testbench

- Register file that sits directly downstream of the instruction decoder.
- Consumes the decoder's register-control bundle (rd/wr enables, addresses, source select, writeback strobe, PC increment, address-drive) and holds A/B/C/D/E/H/L, PC and SP.
- Produces the internal source bus (SBUS), the 16-bit memory address bus and the operand for the ALU.
- Also performs 16-bit pair increment/decrement, which the decoder's 16-bit Inc/Dec group will drive.

---
 rtl/reg_file_pkg.sv | 43 ++++
 rtl/reg_file_reg16_incdec.sv | 25 ++
 rtl/reg_file.sv | 205 ++++++++++++++++++++
 tb/tb_reg_file.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared encodings for the register file and the instruction
// decoder. Both import this package so the decoder's control bundle and the
// register file interpret the same codes.
package reg_file_pkg;

    // 8-bit register select codes (reg_rd_addr / reg_wr_addr / dbg_sel)
    localparam logic [2:0] REG_B  = 3'b000;
    localparam logic [2:0] REG_C  = 3'b001;
    localparam logic [2:0] REG_D  = 3'b010;
    localparam logic [2:0] REG_E  = 3'b011;
    localparam logic [2:0] REG_H  = 3'b100;
    localparam logic [2:0] REG_L  = 3'b101;
    localparam logic [2:0] MEM_HL = 3'b110;  // memory operand, no storage here
    localparam logic [2:0] REG_A  = 3'b111;

    // Write data source selects (reg_src_sel)
    localparam logic [1:0] SRC_SBUS  = 2'b00;
    localparam logic [1:0] SRC_ALU   = 2'b01;
    localparam logic [1:0] SRC_MEM   = 2'b10;
    localparam logic [1:0] SRC_DEBUG = 2'b11;

    // 16-bit pair selects (pair_sel)
    localparam logic [1:0] PAIR_BC = 2'b00;
    localparam logic [1:0] PAIR_DE = 2'b01;
    localparam logic [1:0] PAIR_HL = 2'b10;
    localparam logic [1:0] PAIR_SP = 2'b11;

    // Increment/decrement operation codes (pair_op and the PC incrementer)
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_RSVD = 2'b11   // treated as no operation
    } incdec_op_e;

    // Address-drive decode of reg_rd_addr when reg_drive_addr=1
    localparam logic [2:0] ADDR_PC = 3'b000;
    localparam logic [2:0] ADDR_BC = 3'b100;
    localparam logic [2:0] ADDR_DE = 3'b101;
    localparam logic [2:0] ADDR_HL = 3'b110;
    localparam logic [2:0] ADDR_SP = 3'b111;

endpackage

// File: rtl/reg_file_reg16_incdec.sv
// reg16_incdec: combinational 16-bit increment/decrement, modulo 2^16.
// Ports:
//   value_i  - 16-bit operand
//   op_i     - OP_INC / OP_DEC; OP_NONE and OP_RSVD pass the operand through
//   result_o - operand +/- 1 (or unchanged)
module reg16_incdec
    import reg_file_pkg::*;
(
    input  logic [15:0] value_i,
    input  incdec_op_e  op_i,
    output logic [15:0] result_o
);

    // Select +1, -1 or pass-through; natural 16-bit overflow gives the wrap.
    always_comb begin
        result_o = value_i;
        case (op_i)
            OP_INC:  result_o = value_i + 16'd1;
            OP_DEC:  result_o = value_i - 16'd1;
            OP_NONE: result_o = value_i;
            default: result_o = value_i;
        endcase
    end

endmodule

// File: rtl/reg_file.sv
// reg_file: register file downstream of the instruction decoder.
// Holds A/B/C/D/E/H/L, PC and SP; drives the internal source bus (sbus), the
// 16-bit memory address bus and a debug observe port.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   reg_rd_en/reg_rd_addr  - sbus read select (also pair select for addr_bus)
//   reg_wr_en/reg_wr_addr  - 8-bit write select, data chosen by reg_src_sel
//   reg_drive_addr         - 1: drive selected pair on addr_bus, 0: drive PC
//   reg_writeback          - writeback strobe; qualifies every state update
//   reg_inc_pc             - increment PC on the qualified edge
//   hold                   - suppress all state updates
//   pair_op/pair_sel       - 16-bit pair increment/decrement
//   alu_result, mem_data, debug_data - write data sources
//   sbus, addr_bus         - combinational read outputs
//   dbg_sel/dbg_out        - enable-independent register observe
module reg_file
    import reg_file_pkg::*;
#(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter logic [15:0] SP_RESET = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_rd_en,
    input  logic        reg_wr_en,
    input  logic [2:0]  reg_rd_addr,
    input  logic [2:0]  reg_wr_addr,
    input  logic        reg_drive_addr,
    input  logic [1:0]  reg_src_sel,
    input  logic        reg_writeback,
    input  logic        reg_inc_pc,
    input  logic        hold,
    input  logic [1:0]  pair_op,
    input  logic [1:0]  pair_sel,
    input  logic [7:0]  alu_result,
    input  logic [7:0]  mem_data,
    input  logic [7:0]  debug_data,
    output logic [7:0]  sbus,
    output logic [15:0] addr_bus,
    input  logic [2:0]  dbg_sel,
    output logic [7:0]  dbg_out
);

    logic [7:0]  a_q, b_q, c_q, d_q, e_q, h_q, l_q;
    logic [7:0]  a_d, b_d, c_d, d_d, e_d, h_d, l_d;
    logic [15:0] pc_q, pc_d, sp_q, sp_d;

    logic [7:0]  regs_s [8];
    logic        qualified_s;
    logic [7:0]  wr_data_s;
    logic [15:0] pair_val_s, pair_next_s, pc_next_s;
    incdec_op_e  pc_op_s;

    // Register view indexed by the 3-bit encoding; the MEM_HL slot reads zero.
    always_comb begin
        regs_s[REG_B]  = b_q;
        regs_s[REG_C]  = c_q;
        regs_s[REG_D]  = d_q;
        regs_s[REG_E]  = e_q;
        regs_s[REG_H]  = h_q;
        regs_s[REG_L]  = l_q;
        regs_s[MEM_HL] = 8'h00;
        regs_s[REG_A]  = a_q;
    end

    // Zero-latency read ports.
    always_comb begin
        dbg_out = regs_s[dbg_sel];
        if (reg_rd_en && (reg_rd_addr != MEM_HL)) begin
            sbus = regs_s[reg_rd_addr];
        end else begin
            sbus = 8'h00;
        end
    end

    // Address bus: PC unless a valid pair code is selected for address drive.
    always_comb begin
        addr_bus = pc_q;
        if (reg_drive_addr) begin
            case (reg_rd_addr)
                ADDR_PC: addr_bus = pc_q;
                ADDR_BC: addr_bus = {b_q, c_q};
                ADDR_DE: addr_bus = {d_q, e_q};
                ADDR_HL: addr_bus = {h_q, l_q};
                ADDR_SP: addr_bus = sp_q;
                default: addr_bus = pc_q;
            endcase
        end else begin
            addr_bus = pc_q;
        end
    end

    // Write data source; SBUS is the same-cycle read so LD r,r' takes one edge.
    always_comb begin
        wr_data_s = sbus;
        case (reg_src_sel)
            SRC_SBUS:  wr_data_s = sbus;
            SRC_ALU:   wr_data_s = alu_result;
            SRC_MEM:   wr_data_s = mem_data;
            SRC_DEBUG: wr_data_s = debug_data;
            default:   wr_data_s = sbus;
        endcase
    end

    // Current value of the pair targeted by pair_op.
    always_comb begin
        pair_val_s = {b_q, c_q};
        case (pair_sel)
            PAIR_BC: pair_val_s = {b_q, c_q};
            PAIR_DE: pair_val_s = {d_q, e_q};
            PAIR_HL: pair_val_s = {h_q, l_q};
            PAIR_SP: pair_val_s = sp_q;
            default: pair_val_s = {b_q, c_q};
        endcase
    end

    // PC incrementer operation: only ever +1 or pass-through.
    always_comb begin
        if (reg_inc_pc) begin
            pc_op_s = OP_INC;
        end else begin
            pc_op_s = OP_NONE;
        end
    end

    reg16_incdec u_pc_incdec (
        .value_i  (pc_q),
        .op_i     (pc_op_s),
        .result_o (pc_next_s)
    );

    reg16_incdec u_pair_incdec (
        .value_i  (pair_val_s),
        .op_i     (incdec_op_e'(pair_op)),
        .result_o (pair_next_s)
    );

    assign qualified_s = reg_writeback & ~hold;

    // Next-state: pair result lands first, then an 8-bit write overrides its byte.
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        c_d  = c_q;
        d_d  = d_q;
        e_d  = e_q;
        h_d  = h_q;
        l_d  = l_q;
        pc_d = pc_q;
        sp_d = sp_q;
        if (qualified_s) begin
            pc_d = pc_next_s;
            // With no pair operation pair_next_s equals the pair, so this is a no-op.
            case (pair_sel)
                PAIR_BC: {b_d, c_d} = pair_next_s;
                PAIR_DE: {d_d, e_d} = pair_next_s;
                PAIR_HL: {h_d, l_d} = pair_next_s;
                PAIR_SP: sp_d       = pair_next_s;
                default: sp_d       = sp_q;
            endcase
            if (reg_wr_en) begin
                case (reg_wr_addr)
                    REG_A:   a_d = wr_data_s;
                    REG_B:   b_d = wr_data_s;
                    REG_C:   c_d = wr_data_s;
                    REG_D:   d_d = wr_data_s;
                    REG_E:   e_d = wr_data_s;
                    REG_H:   h_d = wr_data_s;
                    REG_L:   l_d = wr_data_s;
                    default: a_d = a_q;  // MEM_HL has no storage
                endcase
            end else begin
                a_d = a_q;
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // State registers; reset aborts any pending update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= 8'h00;
            b_q  <= 8'h00;
            c_q  <= 8'h00;
            d_q  <= 8'h00;
            e_q  <= 8'h00;
            h_q  <= 8'h00;
            l_q  <= 8'h00;
            pc_q <= PC_RESET;
            sp_q <= SP_RESET;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            c_q  <= c_d;
            d_q  <= d_d;
            e_q  <= e_d;
            h_q  <= h_d;
            l_q  <= l_d;
            pc_q <= pc_d;
            sp_q <= sp_d;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file. A second instance
// with PC_RESET=16'hFFFE exercises PC wrap-around.
module tb_reg_file;
    import reg_file_pkg::*;

    logic        clk;
    logic        rst;
    logic        reg_rd_en, reg_wr_en, reg_drive_addr, reg_writeback;
    logic        reg_inc_pc, hold;
    logic [2:0]  reg_rd_addr, reg_wr_addr, dbg_sel;
    logic [1:0]  reg_src_sel, pair_op, pair_sel;
    logic [7:0]  alu_result, mem_data, debug_data;
    logic [7:0]  sbus, dbg_out, sbus_w, dbg_out_w;
    logic [15:0] addr_bus, addr_bus_w;

    int          check_cnt;
    int          err_cnt;
    logic [7:0]  exp_regs [8];

    reg_file dut (
        .clk(clk), .rst(rst),
        .reg_rd_en(reg_rd_en), .reg_wr_en(reg_wr_en),
        .reg_rd_addr(reg_rd_addr), .reg_wr_addr(reg_wr_addr),
        .reg_drive_addr(reg_drive_addr), .reg_src_sel(reg_src_sel),
        .reg_writeback(reg_writeback), .reg_inc_pc(reg_inc_pc), .hold(hold),
        .pair_op(pair_op), .pair_sel(pair_sel),
        .alu_result(alu_result), .mem_data(mem_data), .debug_data(debug_data),
        .sbus(sbus), .addr_bus(addr_bus), .dbg_sel(dbg_sel), .dbg_out(dbg_out)
    );

    reg_file #(.PC_RESET(16'hFFFE), .SP_RESET(16'hFFFE)) dut_wrap (
        .clk(clk), .rst(rst),
        .reg_rd_en(reg_rd_en), .reg_wr_en(reg_wr_en),
        .reg_rd_addr(reg_rd_addr), .reg_wr_addr(reg_wr_addr),
        .reg_drive_addr(reg_drive_addr), .reg_src_sel(reg_src_sel),
        .reg_writeback(reg_writeback), .reg_inc_pc(reg_inc_pc), .hold(hold),
        .pair_op(pair_op), .pair_sel(pair_sel),
        .alu_result(alu_result), .mem_data(mem_data), .debug_data(debug_data),
        .sbus(sbus_w), .addr_bus(addr_bus_w), .dbg_sel(dbg_sel), .dbg_out(dbg_out_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reg_rd_en = 1'b0; reg_wr_en = 1'b0; reg_drive_addr = 1'b0;
        reg_writeback = 1'b0; reg_inc_pc = 1'b0; hold = 1'b0;
        reg_rd_addr = 3'b000; reg_wr_addr = 3'b000; reg_src_sel = 2'b00;
        pair_op = 2'b00; pair_sel = 2'b00;
    endtask

    // One rising edge with the currently driven controls, then return to idle.
    task automatic edge_then_idle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic qualified_edge();
        reg_writeback = 1'b1;
        edge_then_idle();
    endtask

    task automatic write8(input logic [2:0] addr, input logic [1:0] src, input logic [7:0] data);
        reg_wr_en = 1'b1; reg_wr_addr = addr; reg_src_sel = src;
        alu_result = data; mem_data = data; debug_data = data;
        qualified_edge();
    endtask

    task automatic check_reg(input string tag, input logic [2:0] sel, input logic [7:0] exp);
        dbg_sel = sel;
        #1;
        check_value(tag, {8'h00, dbg_out}, {8'h00, exp});
    endtask

    task automatic check_addr(input string tag, input logic drive, input logic [2:0] sel,
                              input logic [15:0] exp);
        reg_drive_addr = drive; reg_rd_addr = sel;
        #1;
        check_value(tag, addr_bus, exp);
        reg_drive_addr = 1'b0; reg_rd_addr = 3'b000;
    endtask

    initial begin
        check_cnt = 0; err_cnt = 0;
        alu_result = 8'h00; mem_data = 8'h00; debug_data = 8'h00; dbg_sel = 3'b000;
        idle();
        rst = 1'b1;
        #2;
        // reset state
        check_addr("rst_addr", 1'b0, 3'b000, 16'h0000);
        check_addr("rst_sp", 1'b1, ADDR_SP, 16'hFFFE);
        reg_rd_en = 1'b1; reg_rd_addr = REG_A; #1;
        check_value("rst_sbus", {8'h00, sbus}, 16'h0000);
        reg_rd_en = 1'b0;
        check_value("rst_wrap_pc", addr_bus_w, 16'hFFFE);
        @(negedge clk); rst = 1'b0;

        // load B=55, then reset mid-cycle clears it immediately
        write8(REG_B, SRC_MEM, 8'h55);
        check_reg("b_load55", REG_B, 8'h55);
        rst = 1'b1;
        #1;
        check_reg("b_async_rst", REG_B, 8'h00);
        // a write pending across an edge held in reset is aborted
        reg_wr_en = 1'b1; reg_wr_addr = REG_B; reg_src_sel = SRC_MEM; mem_data = 8'h99;
        reg_writeback = 1'b1;
        edge_then_idle();
        check_reg("b_rst_abort", REG_B, 8'h00);
        @(negedge clk); rst = 1'b0;

        // PC wrap on the FFFE-reset instance, with non-qualified edges in between
        reg_inc_pc = 1'b1; qualified_edge();
        check_value("wrap_ffff", addr_bus_w, 16'hFFFF);
        reg_inc_pc = 1'b1; reg_writeback = 1'b0; edge_then_idle();
        check_value("wrap_no_wb", addr_bus_w, 16'hFFFF);
        reg_inc_pc = 1'b1; reg_writeback = 1'b1; hold = 1'b1; edge_then_idle();
        check_value("wrap_hold", addr_bus_w, 16'hFFFF);
        reg_inc_pc = 1'b1; qualified_edge();
        check_value("wrap_0000", addr_bus_w, 16'h0000);
        reg_inc_pc = 1'b1; qualified_edge();
        check_value("wrap_0001", addr_bus_w, 16'h0001);
        check_value("pc_main", addr_bus, 16'h0003);

        // load chain B -> C over sbus
        write8(REG_B, SRC_MEM, 8'h3C);
        reg_rd_en = 1'b1; reg_rd_addr = REG_B; #1;
        check_value("sbus_b", {8'h00, sbus}, 16'h003C);
        reg_wr_en = 1'b1; reg_wr_addr = REG_C; reg_src_sel = SRC_SBUS;
        reg_writeback = 1'b1; hold = 1'b1;
        edge_then_idle();
        check_reg("ldc_hold", REG_C, 8'h00);
        reg_rd_en = 1'b1; reg_rd_addr = REG_B;
        reg_wr_en = 1'b1; reg_wr_addr = REG_C; reg_src_sel = SRC_SBUS;
        edge_then_idle();
        check_reg("ldc_no_wb", REG_C, 8'h00);
        reg_rd_en = 1'b1; reg_rd_addr = REG_B;
        reg_wr_en = 1'b1; reg_wr_addr = REG_C; reg_src_sel = SRC_SBUS;
        qualified_edge();
        check_reg("ldc_done", REG_C, 8'h3C);
        // LD B,B is a no-op
        reg_rd_en = 1'b1; reg_rd_addr = REG_B;
        reg_wr_en = 1'b1; reg_wr_addr = REG_B; reg_src_sel = SRC_SBUS;
        qualified_edge();
        check_reg("ld_bb", REG_B, 8'h3C);

        // other sources
        write8(REG_D, SRC_ALU, 8'h5A);
        write8(REG_E, SRC_DEBUG, 8'hE1);
        write8(REG_A, SRC_MEM, 8'hA5);
        check_reg("d_alu", REG_D, 8'h5A);
        check_reg("e_dbg", REG_E, 8'hE1);
        check_reg("a_mem", REG_A, 8'hA5);

        // pair increment BC 3C3C -> 3C3D, pair decrement DE 5AE1 -> 5AE0
        pair_op = 2'b01; pair_sel = PAIR_BC; qualified_edge();
        check_addr("bc_inc", 1'b1, ADDR_BC, 16'h3C3D);
        pair_op = 2'b10; pair_sel = PAIR_DE; qualified_edge();
        check_addr("de_dec", 1'b1, ADDR_DE, 16'h5AE0);
        pair_op = 2'b11; pair_sel = PAIR_DE; qualified_edge();
        check_addr("de_op11", 1'b1, ADDR_DE, 16'h5AE0);

        // HL decrement colliding with a write of H
        write8(REG_H, SRC_MEM, 8'h01);
        write8(REG_L, SRC_MEM, 8'h00);
        pair_op = 2'b10; pair_sel = PAIR_HL;
        reg_wr_en = 1'b1; reg_wr_addr = REG_H; reg_src_sel = SRC_DEBUG; debug_data = 8'hAA;
        qualified_edge();
        check_reg("coll_h", REG_H, 8'hAA);
        check_reg("coll_l", REG_L, 8'hFF);

        // address drive
        write8(REG_H, SRC_MEM, 8'hC0);
        write8(REG_L, SRC_MEM, 8'h00);
        check_addr("drv_hl", 1'b1, ADDR_HL, 16'hC000);
        check_addr("drv_sp", 1'b1, ADDR_SP, 16'hFFFE);
        check_addr("drv_001", 1'b1, 3'b001, 16'h0003);
        check_addr("drv_010", 1'b1, 3'b010, 16'h0003);
        check_addr("drv_pc0", 1'b0, ADDR_HL, 16'h0003);

        // MEM_HL: write ignored, read returns zero
        exp_regs[REG_B] = 8'h3C; exp_regs[REG_C] = 8'h3D; exp_regs[REG_D] = 8'h5A;
        exp_regs[REG_E] = 8'hE0; exp_regs[REG_H] = 8'hC0; exp_regs[REG_L] = 8'h00;
        exp_regs[MEM_HL] = 8'h00; exp_regs[REG_A] = 8'hA5;
        write8(MEM_HL, SRC_MEM, 8'h77);
        for (int i = 0; i < 8; i++) begin
            check_reg($sformatf("memhl_reg%0d", i), 3'(i), exp_regs[i]);
        end
        reg_rd_en = 1'b1; reg_rd_addr = MEM_HL; #1;
        check_value("sbus_memhl", {8'h00, sbus}, 16'h0000);
        reg_rd_en = 1'b0; reg_rd_addr = REG_A; #1;
        check_value("sbus_rd_off", {8'h00, sbus}, 16'h0000);

        // SP increment wraps FFFE -> FFFF -> 0000
        pair_op = 2'b01; pair_sel = PAIR_SP; qualified_edge();
        check_addr("sp_ffff", 1'b1, ADDR_SP, 16'hFFFF);
        pair_op = 2'b01; pair_sel = PAIR_SP; qualified_edge();
        check_addr("sp_0000", 1'b1, ADDR_SP, 16'h0000);

        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end

endmodule
